// File: rtl/abc_de_pkg.sv
// Shared constants for the a-b-c detector / delayed-response block.
package abc_de_pkg;

  localparam int unsigned E_DLY_MIN = 1;
  localparam int unsigned E_DLY_MAX = 4;
  localparam int unsigned CNT_W_DEF = 8;

endpackage

// File: rtl/abc_de_dly.sv
// Response delay line: every input pulse reappears exactly DEPTH cycles later.
module abc_de_dly
  import abc_de_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in,
  output logic out,
  output logic busy
);

  logic [DEPTH-1:0] sr;

  generate
    if (DEPTH < E_DLY_MIN || DEPTH > E_DLY_MAX) begin : g_bad_depth
      $error("abc_de_dly: DEPTH out of range");
    end
  endgenerate

  // Shifting keeps back-to-back pulses distinct, so each one yields its own strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '0;
    end else begin
      sr <= (sr << 1) | DEPTH'(in);
    end
  end

  assign out = sr[DEPTH-1];

  // Outstanding means a pulse is still travelling and has not reached the output stage.
  generate
    if (DEPTH > 1) begin : g_busy
      assign busy = |sr[DEPTH-2:0];
    end else begin : g_no_busy
      assign busy = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/abc_de_responder.sv
// Detects a##1 b##1 c, acknowledges with d, issues e a fixed delay later, keeps status.
module abc_de_responder
  import abc_de_pkg::*;
#(
  parameter int unsigned E_DLY = 2,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  output logic             d,
  output logic             e,
  output logic             busy,
  output logic [CNT_W-1:0] match_cnt,
  output logic             ovl_err
);

  logic a_q;
  logic ab_q;

  generate
    if (E_DLY < E_DLY_MIN || E_DLY > E_DLY_MAX) begin : g_bad_dly
      $error("abc_de_responder: E_DLY must be in 1..4");
    end
  endgenerate

  // Sequence history runs regardless of en so a match can straddle an en edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q  <= 1'b0;
      ab_q <= 1'b0;
    end else begin
      a_q  <= a;
      ab_q <= a_q & b;
    end
  end

  assign d = ab_q & c & en;

  abc_de_dly #(
    .DEPTH (E_DLY)
  ) u_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (d),
    .out   (e),
    .busy  (busy)
  );

  // Saturating match counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_cnt <= '0;
    end else if (d && (match_cnt != '1)) begin
      match_cnt <= match_cnt + CNT_W'(1);
    end
  end

  // Sticky: a new match arrived before the previous response was issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovl_err <= 1'b0;
    end else if (d && busy) begin
      ovl_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_abc_de_responder.sv
// Directed bench for abc_de_responder: five instances with different delays/widths share one stimulus.
module tb_abc_de_responder;

  localparam int NI   = 5;
  localparam int MAXC = 1024;

  logic clk = 1'b0;
  logic rst_n, en, a, b, c;
  logic d_o [NI];
  logic e_o [NI];
  logic busy_o [NI];
  logic ovl_o [NI];
  logic [7:0] cnt0, cnt2, cnt3, cnt4;
  logic [1:0] cnt1;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 2;
  int rst_start = 0;
  bit a_l [MAXC];
  bit b_l [MAXC];
  bit d_l [NI][MAXC];
  int cnt_m [NI];
  bit ovl_m [NI];

  always #5 clk = ~clk;

  abc_de_responder #(.E_DLY(2), .CNT_W(8)) u_d2 (
    .clk(clk), .rst_n(rst_n), .en(en), .a(a), .b(b), .c(c),
    .d(d_o[0]), .e(e_o[0]), .busy(busy_o[0]), .match_cnt(cnt0), .ovl_err(ovl_o[0]));
  abc_de_responder #(.E_DLY(2), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .a(a), .b(b), .c(c),
    .d(d_o[1]), .e(e_o[1]), .busy(busy_o[1]), .match_cnt(cnt1), .ovl_err(ovl_o[1]));
  abc_de_responder #(.E_DLY(4), .CNT_W(8)) u_d4 (
    .clk(clk), .rst_n(rst_n), .en(en), .a(a), .b(b), .c(c),
    .d(d_o[2]), .e(e_o[2]), .busy(busy_o[2]), .match_cnt(cnt2), .ovl_err(ovl_o[2]));
  abc_de_responder #(.E_DLY(3), .CNT_W(8)) u_d3 (
    .clk(clk), .rst_n(rst_n), .en(en), .a(a), .b(b), .c(c),
    .d(d_o[3]), .e(e_o[3]), .busy(busy_o[3]), .match_cnt(cnt3), .ovl_err(ovl_o[3]));
  abc_de_responder #(.E_DLY(1), .CNT_W(8)) u_d1 (
    .clk(clk), .rst_n(rst_n), .en(en), .a(a), .b(b), .c(c),
    .d(d_o[4]), .e(e_o[4]), .busy(busy_o[4]), .match_cnt(cnt4), .ovl_err(ovl_o[4]));

  // Temporal properties: a completed sequence is acknowledged and answered E_DLY cycles later.
  ap_d2: assert property (@(posedge clk) disable iff (!rst_n)
    (a ##1 b ##1 (c && en)) |-> (d_o[0] ##2 e_o[0]))
    else begin miscompares++; $display("FAIL ap_d2 at %0t: got no e 2 cycles after d, required e", $time); end
  ap_d4: assert property (@(posedge clk) disable iff (!rst_n)
    (a ##1 b ##1 (c && en)) |-> (d_o[2] ##4 e_o[2]))
    else begin miscompares++; $display("FAIL ap_d4 at %0t: got no e 4 cycles after d, required e", $time); end
  ap_d3: assert property (@(posedge clk) disable iff (!rst_n)
    (a ##1 b ##1 (c && en)) |-> (d_o[3] ##3 e_o[3]))
    else begin miscompares++; $display("FAIL ap_d3 at %0t: got no e 3 cycles after d, required e", $time); end
  ap_d1: assert property (@(posedge clk) disable iff (!rst_n)
    (a ##1 b ##1 (c && en)) |-> (d_o[4] ##1 e_o[4]))
    else begin miscompares++; $display("FAIL ap_d1 at %0t: got no e 1 cycle after d, required e", $time); end

  function automatic int dly_of(input int k);
    case (k)
      0, 1:    return 2;
      2:       return 4;
      3:       return 3;
      default: return 1;
    endcase
  endfunction

  function automatic int cmax_of(input int k);
    return (k == 1) ? 3 : 255;
  endfunction

  function automatic int cnt_of(input int k);
    case (k)
      0:       return int'(cnt0);
      1:       return int'(cnt1);
      2:       return int'(cnt2);
      3:       return int'(cnt3);
      default: return int'(cnt4);
    endcase
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d", nm, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare every instance against the model, then advance it.
  task automatic step(input bit ia, input bit ib, input bit ic, input bit ien, input bit irst);
    int t;
    int ed;
    bit dx;
    bit ex;
    bit bx;
    @(negedge clk);
    a = ia; b = ib; c = ic; en = ien; rst_n = irst;
    #1;
    t = cyc;
    if (!irst) begin
      rst_start = t + 1;
      for (int k = 0; k < NI; k++) begin
        cnt_m[k] = 0;
        ovl_m[k] = 1'b0;
      end
    end
    a_l[t] = ia;
    b_l[t] = ib;
    dx = irst && ien && ic && (t - 2 >= rst_start) && b_l[t-1] && a_l[t-2];
    for (int k = 0; k < NI; k++) begin
      ed = dly_of(k);
      ex = irst && (t - ed >= rst_start) && d_l[k][t-ed];
      bx = 1'b0;
      for (int j = 1; j < ed; j++) begin
        if ((t - j >= rst_start) && d_l[k][t-j]) bx = 1'b1;
      end
      bx = bx && irst;
      chk($sformatf("d[%0d]@%0d", k, t), int'(d_o[k]), int'(dx));
      chk($sformatf("e[%0d]@%0d", k, t), int'(e_o[k]), int'(ex));
      chk($sformatf("busy[%0d]@%0d", k, t), int'(busy_o[k]), int'(bx));
      chk($sformatf("match_cnt[%0d]@%0d", k, t), cnt_of(k), cnt_m[k]);
      chk($sformatf("ovl_err[%0d]@%0d", k, t), int'(ovl_o[k]), int'(ovl_m[k]));
      d_l[k][t] = dx;
      if (dx && cnt_m[k] < cmax_of(k)) cnt_m[k]++;
      if (dx && bx) ovl_m[k] = 1'b1;
    end
    if (cyc < MAXC - 1) begin
      cyc++;
    end else begin
      $display("FAIL cycle_budget: got %0d cycles, required fewer than %0d", cyc, MAXC);
      $fatal(1, "cycle budget exhausted");
    end
  endtask

  task automatic do_reset();
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
  endtask

  task automatic idle(input int n, input bit ien);
    for (int i = 0; i < n; i++) step(0, 0, 0, ien, 1);
  endtask

  task automatic abc_seq(input bit ien);
    step(1, 0, 0, ien, 1);
    step(0, 1, 0, ien, 1);
    step(0, 0, 1, ien, 1);
  endtask

  int sat_exp [5] = '{1, 2, 3, 3, 3};

  initial begin
    rst_n = 1'b0; en = 1'b0; a = 1'b0; b = 1'b0; c = 1'b0;

    // Single match: d on cycle 3, e on cycle 5 (E_DLY=2) and cycle 4 (E_DLY=1).
    do_reset();
    chk("reset busy", int'(busy_o[0]), 0);
    chk("reset cnt", int'(cnt0), 0);
    abc_seq(1);
    chk("single d@3", int'(d_o[0]), 1);
    step(0, 0, 0, 1, 1);
    chk("single e1@4", int'(e_o[4]), 1);
    step(0, 0, 0, 1, 1);
    chk("single e@5", int'(e_o[0]), 1);
    idle(2, 1);
    chk("single cnt", int'(cnt0), 1);
    chk("single ovl", int'(ovl_o[0]), 0);

    // Continuous match: overlapping detection, overlap error.
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      step(1, 1, 1, 1, 1);
      if (i == 2) chk("cont d@2", int'(d_o[0]), 0);
      if (i == 3) chk("cont d@3", int'(d_o[0]), 1);
    end
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 1);
    chk("cont e@12", int'(e_o[0]), 1);
    step(0, 0, 0, 1, 1);
    chk("cont e@13", int'(e_o[0]), 0);
    chk("cont ovl", int'(ovl_o[0]), 1);
    chk("cont cnt", int'(cnt0), 8);

    // Saturation with a 2-bit counter.
    do_reset();
    for (int m = 0; m < 5; m++) begin
      abc_seq(1);
      step(0, 0, 0, 1, 1);
      chk($sformatf("sat cnt#%0d", m), int'(cnt1), sat_exp[m]);
      idle(2, 1);
    end

    // Broken sequence: b missing.
    do_reset();
    step(1, 0, 0, 1, 1);
    step(0, 0, 0, 1, 1);
    step(0, 0, 1, 1, 1);
    chk("broken d@3", int'(d_o[0]), 0);
    idle(3, 1);
    chk("broken cnt", int'(cnt0), 0);

    // Reset while a response is outstanding (E_DLY=4).
    do_reset();
    abc_seq(1);
    chk("rst d4@3", int'(d_o[2]), 1);
    step(0, 0, 0, 1, 1);
    chk("rst busy4@4", int'(busy_o[2]), 1);
    step(0, 0, 0, 1, 0);
    chk("rst busy4@5", int'(busy_o[2]), 0);
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 0, 1, 1);
      chk($sformatf("rst e4 +%0d", i), int'(e_o[2]), 0);
    end

    // en gating (E_DLY=3): in-flight e survives, new match suppressed.
    do_reset();
    abc_seq(1);
    step(1, 0, 0, 0, 1);
    step(0, 1, 0, 0, 1);
    step(0, 0, 1, 0, 1);
    chk("en e3@6", int'(e_o[3]), 1);
    chk("en d3@6", int'(d_o[3]), 0);
    idle(4, 0);
    chk("en cnt3", int'(cnt3), 1);

    // History runs while en is low; en only needed in the c cycle.
    do_reset();
    step(1, 0, 0, 0, 1);
    step(0, 1, 0, 0, 1);
    step(0, 0, 1, 1, 1);
    chk("hist d@3", int'(d_o[0]), 1);
    idle(5, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
